// File: rtl/dshot_pkg.sv
// Shared DSHOT definitions: frame width, receive FSM states and the 4-bit frame checksum.
package dshot_pkg;

    localparam int DSHOT_BITS = 16;

    typedef enum logic [2:0] {
        GAP  = 3'd0,
        IDLE = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        DONE = 3'd4
    } dshot_state_e;

    function automatic logic [3:0] dshot_crc(input logic [11:0] v);
        logic [11:0] x;
        x = v ^ (v >> 4) ^ (v >> 8);
        return x[3:0];
    endfunction

endpackage

// File: rtl/dshot_rx_sync.sv
// Brings the asynchronous motor line into the clock domain, normalises its polarity
// so that idle is always low, and flags rising and falling edges.
module dshot_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic inv,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic line_s;
    logic q_q;
    logic rise_q;
    logic fall_q;

    assign line_s = sync_q ^ inv;

    // Two-flop synchronizer; resets to the wire's idle level so line_s starts low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= inv;
            sync_q <= inv;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    // Registered line and edge flags, all aligned to the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            q_q    <= line_s;
            rise_q <= line_s & ~q_q;
            fall_q <= ~line_s & q_q;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/dshot_rx_decoder.sv
// DSHOT frame receiver: classifies each bit by its high time, assembles 16 bits,
// checks the checksum and flags glitched, stuck-high or truncated frames.
module dshot_rx_decoder
    import dshot_pkg::*;
#(
    parameter int BIT_CYCLES    = 45,
    parameter int THRESH_CYCLES = BIT_CYCLES / 2,
    parameter int MIN_HIGH      = 4,
    parameter int IDLE_CYCLES   = 2 * BIT_CYCLES,
    parameter bit INVERTED      = 1'b0
) (
    input  logic        i_clk,
    input  logic        por_reset_27m,
    input  logic        i_enable,
    input  logic        i_dshot,
    output logic        o_frame_valid,
    output logic [10:0] o_throttle,
    output logic        o_telem_req,
    output logic        o_crc_ok,
    output logic        o_frame_err,
    output logic [15:0] o_frame_cnt,
    output logic        o_busy
);

    localparam int            CW       = $clog2(IDLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] IDLE_M1  = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] BIT_M1   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] THRESH   = CW'(THRESH_CYCLES);
    localparam logic [CW-1:0] MIN_H    = CW'(MIN_HIGH);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [4:0]    LAST_BIT = 5'(DSHOT_BITS - 1);

    dshot_state_e  state_q, state_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [4:0]    bidx_q, bidx_d;
    logic [15:0]   sr_q, sr_d;
    logic          err_d;
    logic          load_s;
    logic          busy_d;
    logic          line_s, rise_s, fall_s;

    logic          valid_q, err_q, telem_q, crc_ok_q, busy_q;
    logic [10:0]   throttle_q;
    logic [15:0]   cnt_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    dshot_rx_sync u_sync (
        .clk  (i_clk),
        .rst  (por_reset_27m),
        .d    (i_dshot),
        .inv  (INVERTED),
        .q    (line_s),
        .rise (rise_s),
        .fall (fall_s)
    );

    // State and bit-assembly registers.
    always_ff @(posedge i_clk or posedge por_reset_27m) begin
        if (por_reset_27m) begin
            state_q <= GAP;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
            bidx_q  <= 5'd0;
            sr_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
            bidx_q  <= bidx_d;
            sr_q    <= sr_d;
        end
    end

    // Next-state and counter logic; GAP ignores rises so a frame is never joined mid-stream.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        bidx_d  = bidx_q;
        sr_d    = sr_q;
        err_d   = 1'b0;
        if (!i_enable) begin
            state_d = GAP;
            lcnt_d  = '0;
        end else begin
            case (state_q)
                GAP: begin
                    lcnt_d = line_s ? '0 : sat_inc(lcnt_q);
                    if (!line_s && (lcnt_q >= IDLE_M1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
                IDLE: begin
                    if (rise_s) begin
                        state_d = HIGH;
                        hcnt_d  = ONE;
                        bidx_d  = 5'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                HIGH: begin
                    if (fall_s) begin
                        if (hcnt_q < MIN_H) begin
                            err_d   = 1'b1;
                            state_d = GAP;
                            lcnt_d  = '0;
                        end else begin
                            sr_d    = {sr_q[14:0], (hcnt_q >= THRESH)};
                            bidx_d  = bidx_q + 5'd1;
                            lcnt_d  = ONE;
                            state_d = (bidx_q == LAST_BIT) ? DONE : LOW;
                        end
                    end else if (hcnt_q >= BIT_M1) begin
                        err_d   = 1'b1;
                        state_d = GAP;
                        lcnt_d  = '0;
                    end else begin
                        hcnt_d = sat_inc(hcnt_q);
                    end
                end
                LOW: begin
                    if (rise_s) begin
                        state_d = HIGH;
                        hcnt_d  = ONE;
                    end else if (lcnt_q >= IDLE_M1) begin
                        // Line has already idled long enough, so skip GAP.
                        err_d   = 1'b1;
                        state_d = IDLE;
                        lcnt_d  = sat_inc(lcnt_q);
                    end else begin
                        lcnt_d = sat_inc(lcnt_q);
                    end
                end
                DONE: begin
                    state_d = GAP;
                    lcnt_d  = line_s ? '0 : sat_inc(lcnt_q);
                end
                default: begin
                    state_d = GAP;
                    lcnt_d  = '0;
                end
            endcase
        end
    end

    // Output decode from the state machine.
    always_comb begin
        load_s = (state_q == DONE) && i_enable;
        busy_d = (state_d == HIGH) || (state_d == LOW);
    end

    // Registered frame results and status pulses.
    always_ff @(posedge i_clk or posedge por_reset_27m) begin
        if (por_reset_27m) begin
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            throttle_q <= 11'd0;
            telem_q    <= 1'b0;
            crc_ok_q   <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            valid_q <= load_s;
            err_q   <= err_d;
            busy_q  <= busy_d;
            if (load_s) begin
                throttle_q <= sr_q[15:5];
                telem_q    <= sr_q[4];
                crc_ok_q   <= (sr_q[3:0] == (dshot_crc(sr_q[15:4]) ^ {4{INVERTED}}));
                cnt_q      <= cnt_q + 16'd1;
            end else begin
                throttle_q <= throttle_q;
                telem_q    <= telem_q;
                crc_ok_q   <= crc_ok_q;
                cnt_q      <= cnt_q;
            end
        end
    end

    assign o_frame_valid = valid_q;
    assign o_frame_err   = err_q;
    assign o_busy        = busy_q;
    assign o_throttle    = throttle_q;
    assign o_telem_req   = telem_q;
    assign o_crc_ok      = crc_ok_q;
    assign o_frame_cnt   = cnt_q;

endmodule

// File: tb/tb_dshot_rx_decoder.sv
// Directed bench for dshot_rx_decoder: a normal-polarity and an inverted instance
// driven with hand-built DSHOT600 frames.
module tb_dshot_rx_decoder;

    logic        clk = 1'b0;
    logic        por = 1'b1;
    logic        en  = 1'b1;
    logic        line_a = 1'b0;
    logic        line_b = 1'b0;
    logic        dshot_b;
    int          cyc = 0;

    logic        valid_a, err_a, tel_a, crc_a, busy_a;
    logic [10:0] thr_a;
    logic [15:0] cnt_a;
    logic        valid_b, err_b, tel_b, crc_b, busy_b;
    logic [10:0] thr_b;
    logic [15:0] cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int va_n = 0, ea_n = 0, vb_n = 0, eb_n = 0, both_n = 0;
    int va_cyc = 0, ea_cyc = 0;
    int fall_cyc = 0;

    assign dshot_b = ~line_b;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (valid_a) begin va_n <= va_n + 1; va_cyc <= cyc; end
        if (err_a)   begin ea_n <= ea_n + 1; ea_cyc <= cyc; end
        if (valid_b) vb_n <= vb_n + 1;
        if (err_b)   eb_n <= eb_n + 1;
        if ((valid_a && err_a) || (valid_b && err_b)) both_n <= both_n + 1;
    end

    dshot_rx_decoder dut_a (
        .i_clk(clk), .por_reset_27m(por), .i_enable(en), .i_dshot(line_a),
        .o_frame_valid(valid_a), .o_throttle(thr_a), .o_telem_req(tel_a),
        .o_crc_ok(crc_a), .o_frame_err(err_a), .o_frame_cnt(cnt_a), .o_busy(busy_a)
    );

    dshot_rx_decoder #(.INVERTED(1'b1)) dut_b (
        .i_clk(clk), .por_reset_27m(por), .i_enable(1'b1), .i_dshot(dshot_b),
        .o_frame_valid(valid_b), .o_throttle(thr_b), .o_telem_req(tel_b),
        .o_crc_ok(crc_b), .o_frame_err(err_b), .o_frame_cnt(cnt_b), .o_busy(busy_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) line_a = v;
        else            line_b = v;
    endtask

    // Logical pulses; the inverted instance sees the complement on its wire.
    task automatic send_frame(input int which, input logic [15:0] val, input int nbits, input int glitch);
        int h;
        for (int i = 0; i < nbits; i++) begin
            h = val[15 - i] ? 34 : 17;
            if (i == glitch) h = 2;
            set_line(which, 1'b1);
            tick(h);
            set_line(which, 1'b0);
            fall_cyc = cyc;
            tick(45 - h);
        end
    endtask

    initial begin
        tick(3);
        @(negedge clk);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_thr", 32'(thr_a), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);
        check("rst_crc", 32'(crc_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_busy_inv", 32'(busy_b), 32'd0);
        @(posedge clk);
        #1;
        por = 1'b0;
        tick(95);

        // Good frame 0x82C6
        send_frame(0, 16'h82C6, 16, -1);
        check("f1_valid_n", 32'(va_n), 32'd1);
        check("f1_latency", 32'(va_cyc - fall_cyc), 32'd5);
        check("f1_thr", 32'(thr_a), 32'd1046);
        check("f1_tel", 32'(tel_a), 32'd0);
        check("f1_crc", 32'(crc_a), 32'd1);
        check("f1_cnt", 32'(cnt_a), 32'd1);
        check("f1_busy", 32'(busy_a), 32'd0);
        tick(100);

        // Bad checksum, then telemetry-only frame
        send_frame(0, 16'h82C7, 16, -1);
        check("f2_valid_n", 32'(va_n), 32'd2);
        check("f2_crc", 32'(crc_a), 32'd0);
        check("f2_thr", 32'(thr_a), 32'd1046);
        tick(100);
        send_frame(0, 16'h0011, 16, -1);
        check("f3_crc", 32'(crc_a), 32'd1);
        check("f3_tel", 32'(tel_a), 32'd1);
        check("f3_thr", 32'(thr_a), 32'd0);
        check("f3_cnt", 32'(cnt_a), 32'd3);
        tick(100);

        // Truncated frame: 10 bits then idle
        send_frame(0, 16'h82C6, 10, -1);
        check("trunc_busy", 32'(busy_a), 32'd1);
        tick(120);
        check("trunc_err_n", 32'(ea_n), 32'd1);
        check("trunc_err_lat", 32'(ea_cyc - fall_cyc), 32'd93);
        check("trunc_valid_n", 32'(va_n), 32'd3);
        check("trunc_thr", 32'(thr_a), 32'd0);
        check("trunc_tel", 32'(tel_a), 32'd1);
        check("trunc_cnt", 32'(cnt_a), 32'd3);

        // Glitch as bit 3, then a clean frame after a full gap
        send_frame(0, 16'h82C6, 16, 3);
        check("glitch_err_n", 32'(ea_n), 32'd2);
        check("glitch_valid_n", 32'(va_n), 32'd3);
        tick(100);
        send_frame(0, 16'h82C6, 16, -1);
        check("post_glitch_valid_n", 32'(va_n), 32'd4);
        check("post_glitch_thr", 32'(thr_a), 32'd1046);
        check("post_glitch_crc", 32'(crc_a), 32'd1);
        check("post_glitch_cnt", 32'(cnt_a), 32'd4);
        tick(100);

        // Inverted line with complemented checksum
        send_frame(1, 16'h82C9, 16, -1);
        check("inv_valid_n", 32'(vb_n), 32'd1);
        check("inv_crc_good", 32'(crc_b), 32'd1);
        check("inv_thr", 32'(thr_b), 32'd1046);
        tick(100);
        send_frame(1, 16'h82C6, 16, -1);
        check("inv_crc_plain", 32'(crc_b), 32'd0);
        check("inv_cnt", 32'(cnt_b), 32'd2);
        check("inv_err_n", 32'(eb_n), 32'd0);
        tick(100);

        // Reset mid-frame, released with the line high, then tightly packed frames
        send_frame(0, 16'h0011, 8, -1);
        set_line(0, 1'b1);
        tick(5);
        por = 1'b1;
        tick(3);
        por = 1'b0;
        tick(10);
        set_line(0, 1'b0);
        tick(20);
        for (int k = 0; k < 3; k++) begin
            send_frame(0, 16'h82C6, 16, -1);
            tick(20);
        end
        check("rst_mid_valid_n", 32'(va_n), 32'd4);
        check("rst_mid_err_n", 32'(ea_n), 32'd2);
        check("rst_mid_cnt", 32'(cnt_a), 32'd0);
        check("rst_mid_thr", 32'(thr_a), 32'd0);
        tick(100);
        send_frame(0, 16'h0011, 16, -1);
        check("rst_after_valid_n", 32'(va_n), 32'd5);
        check("rst_after_cnt", 32'(cnt_a), 32'd1);
        check("rst_after_tel", 32'(tel_a), 32'd1);
        check("rst_after_crc", 32'(crc_a), 32'd1);
        tick(100);

        // Enable dropped mid-frame
        send_frame(0, 16'h82C6, 8, -1);
        set_line(0, 1'b1);
        tick(5);
        en = 1'b0;
        tick(5);
        en = 1'b1;
        tick(10);
        set_line(0, 1'b0);
        tick(20);
        for (int k = 0; k < 2; k++) begin
            send_frame(0, 16'h0011, 16, -1);
            tick(20);
        end
        check("en_mid_valid_n", 32'(va_n), 32'd5);
        check("en_mid_err_n", 32'(ea_n), 32'd2);
        check("en_mid_cnt", 32'(cnt_a), 32'd1);
        tick(100);
        send_frame(0, 16'h82C7, 16, -1);
        check("en_after_valid_n", 32'(va_n), 32'd6);
        check("en_after_crc", 32'(crc_a), 32'd0);
        check("en_after_thr", 32'(thr_a), 32'd1046);
        check("en_after_cnt", 32'(cnt_a), 32'd2);
        tick(10);
        check("never_both", 32'(both_n), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dshot_rx_decoder.md
Name: dshot_rx_decoder

Overview:
Decodes DSHOT frames from a single motor line into throttle, telemetry-request and CRC status. It is the receive-side counterpart of the DSHOT controller. It runs in the 27 MHz input-clock domain and is used for two purposes:
- loop-back checking of motor outputs;
- as the front end for bidirectional (inverted) DSHOT.

It measures the high time of each bit to classify it, assembles 16 bits, checks the CRC, and reports malformed frames.

Parameters:
BIT_CYCLES, 45, nominal bit period in i_clk cycles (DSHOT600 at 27 MHz).
THRESH_CYCLES, BIT_CYCLES/2, high time >= this classifies the bit as 1 (nominal 0 = 37.5%, 1 = 75%).
MIN_HIGH, 4, high pulses shorter than this are glitches and raise a frame error.
IDLE_CYCLES, 2*BIT_CYCLES, low time that marks an inter-frame gap or frame abort.
INVERTED, 0, 1 = bidirectional DSHOT: line polarity inverted and CRC complemented.

Ports:
i_clk  in  1  27 MHz system input clock
por_reset_27m  in  1  asynchronous, active-high reset
i_enable  in  1  decoder enable; low forces state GAP, suppresses all pulses
i_dshot  in  1  raw motor line, asynchronous to i_clk
o_frame_valid  out  1  one-cycle pulse, 16-bit frame captured
o_throttle  out  11  frame bits [15:5], held until next valid frame
o_telem_req  out  1  frame bit [4], held
o_crc_ok  out  1  CRC match for the last valid frame, held
o_frame_err  out  1  one-cycle pulse on malformed frame
o_frame_cnt  out  16  count of valid frames, wraps at 0xFFFF->0
o_busy  out  1  high in states HIGH and LOW

Behaviour:
- Reset values:
  - All outputs are 0 and the shift register is cleared.
  - State is GAP.
  - Synchronizer flops are 0 (after polarity inversion, INVERTED=1 is reset to the idle level).
- Input path:
  - 2-FF synchronizer, then XOR with INVERTED, giving line `s`.
  - Registered edge detect on `s` produces `rise` and `fall`.
  - Latency from pin to edge detect: 3 cycles.
- Counters `hcnt` (high time) and `lcnt` (low time) are $clog2(IDLE_CYCLES+1) bits wide and saturate; they never wrap. `bidx` is 5 bits.
- States:
  - GAP: requires `s` low continuously for IDLE_CYCLES.
    - `lcnt` counts while `s`=0 and clears whenever `s`=1.
    - Move to IDLE when `lcnt` reaches IDLE_CYCLES.
    - A rising edge here is ignored, with no error. This prevents decoding a frame joined mid-stream.
  - IDLE: on `rise`, go to HIGH with `hcnt`=1 and `bidx`=0.
  - HIGH: `hcnt`++ each cycle.
    - On `fall` with `hcnt` < MIN_HIGH: pulse o_frame_err, go to GAP.
    - On `fall` otherwise: shift in bit = (`hcnt` >= THRESH_CYCLES), `bidx`++, `lcnt`=1.
      - If this was bit 16: the next cycle goes to DONE.
      - Otherwise go to LOW.
    - If `hcnt` reaches BIT_CYCLES without a fall: pulse o_frame_err, go to GAP.
  - LOW: `lcnt`++ each cycle.
    - On `rise`: go to HIGH with `hcnt`=1.
    - If `lcnt` reaches IDLE_CYCLES: truncated frame (`bidx` 1..15). Pulse o_frame_err, go to IDLE (the line has already been low IDLE_CYCLES).
  - DONE (1 cycle):
    - Load o_throttle and o_telem_req.
    - o_crc_ok = (sr[3:0] == crc(sr[15:4]) ^ {4{INVERTED}}).
    - Pulse o_frame_valid and increment o_frame_cnt.
    - Go to GAP. A rise during the gap means an over-long frame and is silently ignored, per the GAP rule.
- CRC: crc(v) = (v ^ (v>>4) ^ (v>>8)) & 4'hF, with v a 12-bit value.
- Frames with a bad CRC still pulse o_frame_valid and update the data outputs; o_crc_ok=0.
- On o_frame_err, the data outputs and o_frame_cnt are unchanged.
- o_frame_valid and o_frame_err are never high in the same cycle.
- Latency: o_frame_valid rises 5 cycles after the 16th falling edge at the pin (3 input + HIGH + DONE).
- Reset or i_enable low mid-frame: the partial frame is discarded with no error pulse, and a full GAP is required before the next frame is accepted.

Decomposition:
- Package dshot_pkg:
  - DSHOT_BITS=16;
  - state enum {GAP, IDLE, HIGH, LOW, DONE};
  - function dshot_crc(input [11:0]) returning [3:0]. The DSHOT controller shares this function.
- Sub-module dshot_rx_sync: 2-FF synchronizer, polarity XOR and rise/fall detect.
  - Ports: clk, rst, d, inv, q, rise, fall.

Test Plan:
1. After reset, hold low for 90 cycles, then send frame 0x82C6 (throttle 1046, telem 0, CRC 6) at 45 cycles/bit, with 1 = 34 cycles high and 0 = 17 cycles high -> o_frame_valid pulses once; o_throttle=1046, o_telem_req=0, o_crc_ok=1, o_frame_cnt=1.
2. Send 0x82C7 -> valid pulse with o_crc_ok=0 and o_throttle=1046; then 0x0011 (throttle 0, telem 1, CRC 1) -> o_crc_ok=1, o_telem_req=1, o_frame_cnt=3.
3. Send 10 bits, then hold low -> o_frame_err pulses exactly 90 cycles after the 10th falling edge (+3 input delay); data outputs unchanged; no valid pulse.
4. Frame with a 2-cycle high glitch as bit 3 -> o_frame_err pulse; the next clean frame, sent after a 90-cycle gap, decodes correctly.
5. INVERTED=1: idle-high line, frame with CRC complemented (0x82C9) -> o_crc_ok=1; non-complemented 0x82C6 -> o_crc_ok=0.
6. Assert por_reset_27m at bit 8, release while the line is high, and stream frames back to back with 20-cycle gaps -> no valid or error pulses until a gap of at least 90 cycles precedes a frame, which then decodes. Toggling i_enable low mid-frame gives the same result.
